// File: rtl/sdram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sdram_arb                                                       |
// | Brief    : Three-port rotating-priority arbiter in front of the SDRAM      |
// |            controller; turns level req/ack into rd/wr edges plus ready.    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module sdram_arb (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_word,
    input  logic [24:0] p0_addr,
    input  logic [15:0] p0_din,
    output logic [15:0] p0_dout,
    output logic        p0_ack,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_word,
    input  logic [24:0] p1_addr,
    input  logic [15:0] p1_din,
    output logic [15:0] p1_dout,
    output logic        p1_ack,

    input  logic        p2_req,
    input  logic        p2_we,
    input  logic        p2_word,
    input  logic [24:0] p2_addr,
    input  logic [15:0] p2_din,
    output logic [15:0] p2_dout,
    output logic        p2_ack,

    output logic [24:0] sdram_addr,
    output logic        sdram_rd,
    output logic        sdram_wr,
    output logic        sdram_word,
    output logic [15:0] sdram_din,
    input  logic [15:0] sdram_dout,
    input  logic        sdram_ready
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_gap   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_last;
    logic [1:0]  r_grant;
    logic        r_we;
    logic [2:0]  r_ack;
    logic [15:0] r_dout [0:2];
    logic [24:0] r_sdram_addr;
    logic        r_sdram_rd;
    logic        r_sdram_wr;
    logic        r_sdram_word;
    logic [15:0] r_sdram_din;

    logic [2:0]  w_req;
    logic [2:0]  w_we;
    logic [2:0]  w_word;
    logic [24:0] w_addr [0:2];
    logic [15:0] w_din  [0:2];
    logic [1:0]  w_cand1;
    logic [1:0]  w_cand2;
    logic [1:0]  w_win;
    logic        w_any;

    assign w_req     = {p2_req, p1_req, p0_req};
    assign w_we      = {p2_we, p1_we, p0_we};
    assign w_word    = {p2_word, p1_word, p0_word};
    assign w_addr[0] = p0_addr;
    assign w_addr[1] = p1_addr;
    assign w_addr[2] = p2_addr;
    assign w_din[0]  = p0_din;
    assign w_din[1]  = p1_din;
    assign w_din[2]  = p2_din;
    assign w_any     = |w_req;

    // Search order last+1, last+2, last (mod 3): the previous winner goes last.
    always_comb begin
        w_cand1 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_cand2 = (r_last == 2'd0) ? 2'd2 : r_last - 2'd1;
        if (w_req[w_cand1])
            w_win = w_cand1;
        else if (w_req[w_cand2])
            w_win = w_cand2;
        else
            w_win = r_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_last       <= 2'd2;
            r_grant      <= 2'd0;
            r_we         <= 1'b0;
            r_ack        <= 3'b000;
            for (int i = 0; i < 3; i++)
                r_dout[i] <= 16'h0000;
            r_sdram_addr <= 25'd0;
            r_sdram_rd   <= 1'b0;
            r_sdram_wr   <= 1'b0;
            r_sdram_word <= 1'b0;
            r_sdram_din  <= 16'h0000;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (sdram_ready && w_any) begin
                        r_sdram_addr <= w_addr[w_win];
                        r_sdram_word <= w_word[w_win];
                        r_sdram_din  <= w_din[w_win];
                        r_we         <= w_we[w_win];
                        r_sdram_rd   <= ~w_we[w_win];
                        r_sdram_wr   <= w_we[w_win];
                        r_grant      <= w_win;
                        r_last       <= w_win;
                        r_state      <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    // Controller may be busy with refresh; wait as long as it takes.
                    if (!sdram_ready)
                        r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (sdram_ready) begin
                        r_sdram_rd     <= 1'b0;
                        r_sdram_wr     <= 1'b0;
                        r_ack[r_grant] <= 1'b1;
                        if (!r_we)
                            r_dout[r_grant] <= sdram_dout;
                        r_state <= c_st_gap;
                    end
                end
                c_st_gap: begin
                    // Extra low cycle so the controller always sees a fresh rd/wr edge.
                    r_ack   <= 3'b000;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign p0_ack     = r_ack[0];
    assign p1_ack     = r_ack[1];
    assign p2_ack     = r_ack[2];
    assign p0_dout    = r_dout[0];
    assign p1_dout    = r_dout[1];
    assign p2_dout    = r_dout[2];
    assign sdram_addr = r_sdram_addr;
    assign sdram_rd   = r_sdram_rd;
    assign sdram_wr   = r_sdram_wr;
    assign sdram_word = r_sdram_word;
    assign sdram_din  = r_sdram_din;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sdram_arb                                                    |
// | Brief    : Random requesters and a behavioural SDRAM controller around     |
// |            sdram_arb, checked cycle by cycle against a reference model.    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_sdram_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, we, word;
    logic [24:0] addr [0:2];
    logic [15:0] din  [0:2];
    logic [15:0] dout0, dout1, dout2;
    logic [2:0]  ack;
    logic [24:0] sdram_addr;
    logic        sdram_rd, sdram_wr, sdram_word;
    logic [15:0] sdram_din, sdram_dout;
    logic        sdram_ready;

    always #5 clk = ~clk;

    sdram_arb dut (
        .clk(clk), .reset(reset),
        .p0_req(req[0]), .p0_we(we[0]), .p0_word(word[0]), .p0_addr(addr[0]),
        .p0_din(din[0]), .p0_dout(dout0), .p0_ack(ack[0]),
        .p1_req(req[1]), .p1_we(we[1]), .p1_word(word[1]), .p1_addr(addr[1]),
        .p1_din(din[1]), .p1_dout(dout1), .p1_ack(ack[1]),
        .p2_req(req[2]), .p2_we(we[2]), .p2_word(word[2]), .p2_addr(addr[2]),
        .p2_din(din[2]), .p2_dout(dout2), .p2_ack(ack[2]),
        .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
        .sdram_word(sdram_word), .sdram_din(sdram_din), .sdram_dout(sdram_dout),
        .sdram_ready(sdram_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte-addressed memory behind the controller model.
    logic [7:0]  mem [0:63];
    // Controller model: 0 idle, 1 accepting, 2 busy, 3 start-up busy.
    int          c_state, c_cnt;
    logic [5:0]  c_addr;
    logic        c_we, c_word;
    logic [15:0] c_din;

    // Arbiter reference model.
    int          m_last, fl_port, ack_due, exp_ack_port, w, next_rst;
    bit          m_idle, ack_prev, prev_rw, rw, rise, exp_grant, rst_applied;
    logic        fl_we, fl_word;
    logic [24:0] fl_addr;
    logic [15:0] fl_din, exp_rd_val;
    logic [15:0] exp_dout [0:2];
    logic [15:0] cur_dout [0:2];
    logic [2:0]  exp_ack_vec;

    task automatic new_tx(input int p);
        logic [24:0] a;
        a = 25'($urandom_range(0, 63));
        we[p]   = 1'($urandom_range(0, 1));
        word[p] = 1'($urandom_range(0, 1));
        if (word[p])
            a[0] = 1'b0;
        addr[p] = a;
        din[p]  = 16'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        sdram_ready = 1'b0;
        sdram_dout = 16'h0000;
        req = 3'b000; we = 3'b000; word = 3'b000;
        for (int p = 0; p < 3; p++) begin
            addr[p] = 25'd0; din[p] = 16'h0000; exp_dout[p] = 16'h0000;
        end
        for (int i = 0; i < 64; i++)
            mem[i] = 8'($urandom);
        c_state = 3; c_cnt = 10;
        c_addr = 6'd0; c_we = 1'b0; c_word = 1'b0; c_din = 16'h0000;
        rst_applied = 1'b1;
        m_last = 2; m_idle = 1'b1; fl_port = -1; ack_due = -1; ack_prev = 1'b0;
        prev_rw = 1'b0; next_rst = 500;
        fl_we = 1'b0; fl_word = 1'b0; fl_addr = 25'd0; fl_din = 16'h0000; exp_rd_val = 16'h0000;
        new_tx(0);
        we[0] = 1'b0;
        req[0] = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            rw   = sdram_rd | sdram_wr;
            rise = rw && !prev_rw;
            exp_ack_port = ack_due;
            ack_due = -1;
            cur_dout[0] = dout0; cur_dout[1] = dout1; cur_dout[2] = dout2;

            if (rst_applied) begin
                check_val("rst_rd", sdram_rd, 0);
                check_val("rst_wr", sdram_wr, 0);
                check_val("rst_ack", ack, 0);
                for (int p = 0; p < 3; p++)
                    check_val($sformatf("rst_dout%0d", p), cur_dout[p], 0);
                m_last = 2; m_idle = 1'b1; fl_port = -1; ack_prev = 1'b0;
                exp_ack_port = -1;
                for (int p = 0; p < 3; p++)
                    exp_dout[p] = 16'h0000;
                reset = 1'b0;
                rst_applied = 1'b0;
            end else begin
                if (exp_ack_port >= 0 && !fl_we)
                    exp_dout[exp_ack_port] = exp_rd_val;
                exp_ack_vec = (exp_ack_port >= 0) ? 3'(1 << exp_ack_port) : 3'b000;
                check_val("ack", ack, exp_ack_vec);
                if (exp_ack_port >= 0)
                    check_val("rw_low_at_ack", rw, 0);
                for (int p = 0; p < 3; p++)
                    check_val($sformatf("dout%0d", p), cur_dout[p], exp_dout[p]);

                exp_grant = m_idle && sdram_ready && (req != 3'b000);
                check_val("grant", rise, exp_grant);
                if (exp_grant) begin
                    w = -1;
                    for (int k = 1; k <= 3; k++)
                        if (w < 0 && req[(m_last + k) % 3])
                            w = (m_last + k) % 3;
                    check_val($sformatf("g%0d_addr", w), sdram_addr, addr[w]);
                    check_val($sformatf("g%0d_word", w), sdram_word, word[w]);
                    check_val($sformatf("g%0d_din", w), sdram_din, din[w]);
                    check_val($sformatf("g%0d_wr", w), sdram_wr, we[w]);
                    check_val($sformatf("g%0d_rd", w), sdram_rd, !we[w]);
                    fl_port = w; fl_we = we[w]; fl_word = word[w];
                    fl_addr = addr[w]; fl_din = din[w];
                    m_last = w;
                end
                if (ack_prev)
                    m_idle = 1'b1;
                else if (exp_grant)
                    m_idle = 1'b0;
                ack_prev = (exp_ack_port >= 0);
            end
            prev_rw = rw;

            // Controller model: accepts on a rising rd/wr edge after a random delay.
            if (c_state == 0 && rise) begin
                c_addr = sdram_addr[5:0]; c_we = sdram_wr; c_word = sdram_word; c_din = sdram_din;
                c_state = 1; c_cnt = $urandom_range(0, 5);
            end
            if (c_state == 1) begin
                if (c_cnt == 0) begin
                    sdram_ready = 1'b0; c_state = 2; c_cnt = $urandom_range(1, 5);
                end else c_cnt--;
            end else if (c_state == 2) begin
                if (c_cnt == 0) begin
                    if (c_we) begin
                        mem[c_addr] = c_din[7:0];
                        if (c_word) mem[c_addr | 6'd1] = c_din[15:8];
                    end else begin
                        sdram_dout = c_word ? {mem[c_addr | 6'd1], mem[c_addr]} : {8'h00, mem[c_addr]};
                    end
                    if (fl_port >= 0) begin
                        ack_due = fl_port;
                        exp_rd_val = fl_word ? {mem[fl_addr[5:0] | 6'd1], mem[fl_addr[5:0]]}
                                             : {8'h00, mem[fl_addr[5:0]]};
                    end
                    sdram_ready = 1'b1; c_state = 0;
                end else c_cnt--;
            end else if (c_state == 3) begin
                if (c_cnt == 0) begin
                    sdram_ready = 1'b1; c_state = 0;
                end else c_cnt--;
            end

            // Requesters.
            if (exp_ack_port >= 0) begin
                fl_port = -1;
                if (req[exp_ack_port] && $urandom_range(0, 1) == 1)
                    new_tx(exp_ack_port);
                else
                    req[exp_ack_port] = 1'b0;
            end
            for (int p = 0; p < 3; p++) begin
                if (p == fl_port) begin
                    if (req[p] && $urandom_range(0, 7) == 0) begin
                        req[p] = 1'b0;
                        new_tx(p);
                    end
                end else if (p != exp_ack_port && !req[p] && cyc > 12 && $urandom_range(0, 3) == 0) begin
                    new_tx(p);
                    req[p] = 1'b1;
                end
            end

            // Occasional reset while the controller is busy with a granted access.
            if (cyc >= next_rst && c_state == 2 && c_cnt >= 1 && fl_port >= 0) begin
                reset = 1'b1;
                rst_applied = 1'b1;
                next_rst = next_rst + 500;
                for (int p = 0; p < 3; p++)
                    if (!req[p]) begin
                        new_tx(p);
                        req[p] = 1'b1;
                    end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
